touch_key_gen: RTL and testbench



---
 rtl/touch_key_gen_if.sv | 36 +++
 rtl/touch_key_gen.sv | 148 ++++++++++++++
 tb/tb_touch_key_gen.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/touch_key_gen_if.sv
// -----------------------------------------------------------------------------
// touch_key_gen_if
//   Bundles the request/status signals of the touch-sensor emulator.
//
//   press_req  : start request from the test controller
//   press_cnt  : number of presses in the burst (0..15)
//   touch_key  : emulated capacitive sensor level, 1 = touched
//   busy       : burst in progress
//   done       : one-cycle completion pulse
//
//   master : the side that requests bursts (test controller / bench)
//   slave  : the emulator itself
// -----------------------------------------------------------------------------
interface touch_key_gen_if;
    logic       press_req;
    logic [3:0] press_cnt;
    logic       touch_key;
    logic       busy;
    logic       done;

    modport master (
        output press_req,
        output press_cnt,
        input  touch_key,
        input  busy,
        input  done
    );

    modport slave (
        input  press_req,
        input  press_cnt,
        output touch_key,
        output busy,
        output done
    );
endinterface

// File: rtl/touch_key_gen.sv
// -----------------------------------------------------------------------------
// touch_key_gen
//   Touch-sensor emulator. On request it drives touch_key exactly like the
//   capacitive touch chip would: a burst of N presses, each HOLD_CYC cycles
//   high followed by GAP_CYC cycles low, then a one-cycle done pulse.
//
//   Parameters
//     CNT_W     width of the hold/gap timing counter
//     HOLD_CYC  cycles touch_key stays high per press (>= 1)
//     GAP_CYC   cycles touch_key stays low after each press (>= 1)
//
//   Ports
//     sys_clk    system clock
//     sys_rst_n  asynchronous active-low reset
//     bus        touch_key_gen_if.slave:
//                  press_req (in)  start request, only honoured in IDLE
//                  press_cnt (in)  presses in burst, latched at acceptance
//                  touch_key (out) emulated sensor level
//                  busy      (out) high while PRESS/GAP
//                  done      (out) one-cycle pulse at burst completion
//
//   All outputs are registered. The output registers load values derived from
//   the next state, so touch_key/busy change on the same edge the state does.
// -----------------------------------------------------------------------------
module touch_key_gen #(
    parameter int CNT_W    = 24,
    parameter int HOLD_CYC = 12_500_000,
    parameter int GAP_CYC  = 5_000_000
) (
    input  logic            sys_clk,
    input  logic            sys_rst_n,
    touch_key_gen_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRESS = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    // Terminal counts: a phase lasts exactly N cycles when the counter,
    // cleared on entry, is compared against N-1.
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYC - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] tcnt_q,  tcnt_d;      // cycles spent in current phase
    logic [3:0]       pcnt_q,  pcnt_d;      // presses still to finish
    logic             touch_key_q, touch_key_d;
    logic             busy_q,      busy_d;
    logic             done_q,      done_d;

    // Completion events, produced by the next-state logic for the output logic
    logic             zero_burst;           // accepted request with count 0
    logic             burst_end;            // gap of the last press expires

    // ------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q     <= ST_IDLE;
            tcnt_q      <= '0;
            pcnt_q      <= '0;
            touch_key_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            tcnt_q      <= tcnt_d;
            pcnt_q      <= pcnt_d;
            touch_key_q <= touch_key_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        tcnt_d     = tcnt_q;
        pcnt_d     = pcnt_q;
        zero_burst = 1'b0;
        burst_end  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                tcnt_d = '0;
                // Also taken in the done cycle: a new burst may start there.
                if (bus.press_req) begin
                    pcnt_d = bus.press_cnt;
                    if (bus.press_cnt != 4'd0) begin
                        state_d = ST_PRESS;
                    end else begin
                        zero_burst = 1'b1;
                    end
                end
            end

            ST_PRESS: begin
                if (tcnt_q == HOLD_LAST) begin
                    state_d = ST_GAP;
                    tcnt_d  = '0;
                end else begin
                    tcnt_d  = tcnt_q + CNT_W'(1);
                end
            end

            ST_GAP: begin
                if (tcnt_q == GAP_LAST) begin
                    tcnt_d = '0;
                    pcnt_d = pcnt_q - 4'd1;
                    // pcnt_q counts the press whose gap is ending now.
                    if (pcnt_q == 4'd1) begin
                        state_d   = ST_IDLE;
                        burst_end = 1'b1;
                    end else begin
                        state_d   = ST_PRESS;
                    end
                end else begin
                    tcnt_d = tcnt_q + CNT_W'(1);
                end
            end

            default: begin
                state_d = ST_IDLE;
                tcnt_d  = '0;
                pcnt_d  = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output logic (feeds the output registers)
    // ------------------------------------------------------------------
    always_comb begin
        touch_key_d = (state_d == ST_PRESS);
        busy_d      = (state_d != ST_IDLE);
        done_d      = zero_burst | burst_end;
    end

    assign bus.touch_key = touch_key_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;

endmodule

// File: tb/tb_touch_key_gen.sv
// -----------------------------------------------------------------------------
// tb_touch_key_gen
//   Directed bench for touch_key_gen with HOLD_CYC=4, GAP_CYC=3.
//   Inputs change and outputs are sampled on the falling clock edge; the
//   cycle index j below means "just after rising edge E0+j".
// -----------------------------------------------------------------------------
module tb_touch_key_gen;

    localparam int H = 4;
    localparam int G = 3;
    localparam int P = H + G;

    logic sys_clk   = 1'b0;
    logic sys_rst_n = 1'b1;

    touch_key_gen_if bus ();

    touch_key_gen #(
        .CNT_W    (24),
        .HOLD_CYC (H),
        .GAP_CYC  (G)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .bus       (bus)
    );

    always #5 sys_clk = ~sys_clk;

    int   n_vec = 0;
    int   n_err = 0;
    int   rises = 0;
    int   falls = 0;
    logic led   = 1'b0;     // model of the downstream edge-detect/LED-toggle
    logic prev_tk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Issue a request with press_cnt=cnt at the next rising edge (E0) and
    // check every cycle up to one past the done pulse. Optionally re-raise
    // press_req so that it is sampled at edge E0+re_cyc with count re_cnt.
    task automatic run_burst(input int cnt, input int n_exp, input int re_cyc,
                             input int re_cnt, input string name);
        int   last;
        logic exp_tk;
        last          = n_exp * P;
        bus.press_req = 1'b1;
        bus.press_cnt = 4'(cnt);
        rises         = 0;
        falls         = 0;
        prev_tk       = bus.touch_key;
        for (int j = 0; j <= last + 1; j++) begin
            @(negedge sys_clk);
            bus.press_req = (j == re_cyc - 1);
            if (j == re_cyc - 1) bus.press_cnt = 4'(re_cnt);
            exp_tk = (j < last) && ((j % P) < H);
            chk($sformatf("%s touch_key c%0d", name, j), 32'(bus.touch_key), 32'(exp_tk));
            chk($sformatf("%s busy c%0d", name, j), 32'(bus.busy), 32'(j < last));
            chk($sformatf("%s done c%0d", name, j), 32'(bus.done), 32'(j == last));
            if (prev_tk && !bus.touch_key) begin
                falls++;
                led = ~led;
            end
            if (!prev_tk && bus.touch_key) rises++;
            prev_tk = bus.touch_key;
        end
        chk($sformatf("%s rises", name), 32'(rises), 32'(n_exp));
        chk($sformatf("%s falls", name), 32'(falls), 32'(n_exp));
        $display("%s: press_cnt=%0d presses=%0d done_at=E%0d", name, cnt, rises, last);
    endtask

    initial begin
        bus.press_req = 1'b0;
        bus.press_cnt = 4'd0;

        // T1: reset values, held for 5 cycles
        #3 sys_rst_n = 1'b0;
        #1;
        chk("T1 touch_key", 32'(bus.touch_key), 32'd0);
        chk("T1 busy",      32'(bus.busy),      32'd0);
        chk("T1 done",      32'(bus.done),      32'd0);
        for (int i = 0; i < 5; i++) begin
            @(negedge sys_clk);
            chk($sformatf("T1 hold touch_key c%0d", i), 32'(bus.touch_key), 32'd0);
            chk($sformatf("T1 hold busy c%0d", i),      32'(bus.busy),      32'd0);
            chk($sformatf("T1 hold done c%0d", i),      32'(bus.done),      32'd0);
        end
        sys_rst_n = 1'b1;
        $display("T1: reset held 5 cycles");
        @(negedge sys_clk);

        // T2: single press
        run_burst(1, 1, -1, 0, "T2");

        // T3: burst of 3, LED toggles 3 times from 0 -> ends at 1
        led = 1'b0;
        run_burst(3, 3, -1, 0, "T3");
        chk("T3 led", 32'(led), 32'd1);

        // T4: zero count
        run_burst(0, 0, -1, 0, "T4");

        // T5: request at E2 with count 5 while busy is ignored
        run_burst(2, 2, 2, 5, "T5");

        // T6: reset asynchronously shortly after E2 during the first press
        bus.press_req = 1'b1;
        bus.press_cnt = 4'd1;
        @(negedge sys_clk);
        bus.press_req = 1'b0;
        chk("T6 touch_key before reset", 32'(bus.touch_key), 32'd1);
        @(posedge sys_clk);
        @(posedge sys_clk);
        #2 sys_rst_n = 1'b0;
        #1;
        chk("T6 touch_key async", 32'(bus.touch_key), 32'd0);
        chk("T6 busy async",      32'(bus.busy),      32'd0);
        chk("T6 done async",      32'(bus.done),      32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge sys_clk);
            chk($sformatf("T6 in-reset done c%0d", i),      32'(bus.done),      32'd0);
            chk($sformatf("T6 in-reset touch_key c%0d", i), 32'(bus.touch_key), 32'd0);
        end
        sys_rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge sys_clk);
            chk($sformatf("T6 post-reset done c%0d", i), 32'(bus.done), 32'd0);
            chk($sformatf("T6 post-reset busy c%0d", i), 32'(bus.busy), 32'd0);
        end
        $display("T6: reset mid-press, burst abandoned without done");
        run_burst(1, 1, -1, 0, "T6b");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
